// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold values up to WIDTH-1 and still be at least one bit wide.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle of the bit-serial adder; the requester is the master,
// the adder is the slave.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_bit.sv
// One-bit full-adder cell; the serial controller time-multiplexes it over
// every bit position of the operands.
module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder: latches operands on start, pushes one bit pair
// per clock through a single full-adder cell, publishes {cout,sum} on done.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cell_sum;
  logic               cell_co;
  logic               accept;
  logic [WIDTH:0]     res_cat;

  serial_add_bit u_bit (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (cell_sum),
    .co (cell_co)
  );

  // Start is only honoured when no operation is in flight.
  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    // Concatenate-then-slice keeps the right-shift legal even for WIDTH=1.
    res_cat  = {cell_sum, res_sh_q};

    unique case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        carry_d  = cell_co;
        res_sh_d = res_cat[WIDTH:1];
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          sum_d   = res_cat[WIDTH:1];
          cout_d  = cell_co;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d  = ST_RUN;
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      carry_d  = bus.cin;
      cnt_d    = '0;
      res_sh_d = '0;
    end
  end

  // NOTE: sequential state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed and random checks of serial_add at WIDTH=8, WIDTH=1 and WIDTH=32.
module tb_serial_add;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  serial_add_if #(.WIDTH(8))  if8  ();
  serial_add_if #(.WIDTH(1))  if1  ();
  serial_add_if #(.WIDTH(32)) if32 ();

  serial_add #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_add #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_add #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (if8.done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    step();
    if8.start = 1'b0;
    check({tag, ".busy"}, 64'(if8.busy), 64'd1);
    wait_done8(n);
    check({tag, ".latency"}, 64'(n), 64'd8);
    check({tag, ".sum"}, 64'(if8.sum), 64'(exp_sum));
    check({tag, ".cout"}, 64'(if8.cout), 64'(exp_cout));
  endtask

  initial begin
    int          n;
    int          last_done;
    logic        seen;
    logic [1:0]  e1;
    logic [32:0] e32;

    rst = 1'b1;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
    if1.start = 1'b0;  if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;
    if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
    repeat (2) step();
    check("reset.busy", 64'(if8.busy), 64'd0);
    check("reset.done", 64'(if8.done), 64'd0);
    check("reset.sum",  64'(if8.sum),  64'd0);
    check("reset.cout", 64'(if8.cout), 64'd0);
    rst = 1'b0;
    step();

    op8("basic", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
    step();
    check("basic.pulse", 64'(if8.done), 64'd0);
    check("basic.held",  64'(if8.sum),  64'h96);

    // Result must stay at the previous value for every RUN cycle of the next op.
    if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0;
    step();
    if8.start = 1'b0;
    n = 0;
    while (if8.done !== 1'b1 && n < 40) begin
      check("hold.sum", 64'(if8.sum), 64'h96);
      step();
      n++;
    end
    check("hold.latency", 64'(n), 64'd8);
    check("hold.new_sum", 64'(if8.sum), 64'h02);

    op8("carry_ff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("carry_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // start held high across RUN; operands change mid-run and are picked up only from DONE.
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
    step();
    if8.a = 8'h05; if8.b = 8'h06;
    wait_done8(n);
    check("busy_start.latency", 64'(n), 64'd8);
    check("busy_start.sum",  64'(if8.sum),  64'h30);
    check("busy_start.cout", 64'(if8.cout), 64'd0);
    step();
    check("b2b.busy", 64'(if8.busy), 64'd1);
    check("b2b.done", 64'(if8.done), 64'd0);
    if8.start = 1'b0;
    wait_done8(n);
    check("b2b.latency", 64'(n), 64'd8);
    check("b2b.sum",  64'(if8.sum),  64'h0B);
    check("b2b.cout", 64'(if8.cout), 64'd0);

    op8("pre_reset", 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1);

    if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'h22; if8.cin = 1'b0;
    step();
    if8.start = 1'b0;
    repeat (3) step();
    check("midrst.running", 64'(if8.busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst.busy", 64'(if8.busy), 64'd0);
    check("midrst.done", 64'(if8.done), 64'd0);
    check("midrst.sum",  64'(if8.sum),  64'd0);
    check("midrst.cout", 64'(if8.cout), 64'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (if8.done === 1'b1) seen = 1'b1;
    end
    check("midrst.no_done", 64'(seen), 64'd0);
    op8("fresh", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // WIDTH=1 under continuous start: random operands, done every 2 cycles.
    if1.start = 1'b1;
    if1.a = 1'($urandom); if1.b = 1'($urandom); if1.cin = 1'($urandom);
    e1 = 2'(if1.a) + 2'(if1.b) + 2'(if1.cin);
    step();
    last_done = 0;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (if1.done !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      check("w1.latency", 64'(n), 64'd1);
      check("w1.result", 64'({if1.cout, if1.sum}), 64'(e1));
      if (i > 0) check("w1.spacing", 64'(cycle - last_done), 64'd2);
      last_done = cycle;
      if1.a = 1'($urandom); if1.b = 1'($urandom); if1.cin = 1'($urandom);
      e1 = 2'(if1.a) + 2'(if1.b) + 2'(if1.cin);
      step();
    end
    if1.start = 1'b0;

    // WIDTH=32 under continuous start: done every 33 cycles.
    if32.start = 1'b1;
    if32.a = $urandom; if32.b = $urandom; if32.cin = 1'($urandom);
    e32 = 33'(if32.a) + 33'(if32.b) + 33'(if32.cin);
    step();
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (if32.done !== 1'b1 && n < 80) begin
        step();
        n++;
      end
      check("w32.latency", 64'(n), 64'd32);
      check("w32.result", 64'({if32.cout, if32.sum}), 64'(e32));
      if (i > 0) check("w32.spacing", 64'(cycle - last_done), 64'd33);
      last_done = cycle;
      if32.a = $urandom; if32.b = $urandom; if32.cin = 1'($urandom);
      e32 = 33'(if32.a) + 33'(if32.b) + 33'(if32.cin);
      step();
    end
    if32.start = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
